// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller: FSM encoding,
// the data-segment base address and the halfword select constants.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int   DATA_BASE_ADDR = 1024;
  localparam logic HALF_LO        = 1'b0;
  localparam logic HALF_HI        = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts the clock cycles spent in one 16-bit SRAM phase and flags
// the final cycle of that phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic last_cycle
);

  logic [7:0] count;

  // Reload has priority so a phase always starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign last_cycle = (count == 8'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_ctrl.sv
// MEM-stage controller that splits each 32-bit load/store into two 16-bit
// asynchronous SRAM cycles and stalls the pipeline via ready until it finishes.
module sram_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DATA_BASE_ADDR,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  state_t             state;
  state_t             state_next;
  logic               req;
  logic               latch_req;
  logic               cnt_load;
  logic               cnt_en;
  logic               last_cycle;
  logic               in_phase;
  logic               half_sel;
  logic               is_wr_q;
  logic [SRAM_AW-2:0] idx_q;
  logic [31:0]        wd_q;

  assign req = MEM_R_EN | MEM_W_EN;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .enable     (cnt_en),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = LO;
          latch_req  = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      LO: begin
        if (last_cycle) begin
          state_next = HI;
          cnt_load   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HI: begin
        if (last_cycle) begin
          state_next = DONE;
          cnt_load   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only in IDLE; a write wins when both enables are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
    end else if (latch_req) begin
      is_wr_q <= MEM_W_EN;
      idx_q   <= (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
      wd_q    <= write_data;
    end
  end

  assign in_phase = (state == LO) || (state == HI);
  assign half_sel = (state == HI) ? HALF_HI : HALF_LO;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (in_phase && !is_wr_q && last_cycle) begin
      if (half_sel == HALF_HI) begin
        read_data[31:16] <= sram_dq_in;
      end else begin
        read_data[15:0] <= sram_dq_in;
      end
    end
  end

  // The strobe releases in the last cycle of a phase so address and data are held
  // past the rising edge of we_n; a single-cycle phase has no room for that.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (in_phase) begin
      sram_addr = {idx_q, half_sel};
      if (is_wr_q) begin
        sram_dq_out = (half_sel == HALF_HI) ? wd_q[31:16] : wd_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = !(!last_cycle || (WAIT_CYCLES == 1));
      end
    end
  end

  assign ready = ((state == IDLE) && !req) || (state == DONE);

endmodule
